// File: rtl/shape_cmd_sequencer.sv
// shape_cmd_sequencer: buffers SFR access commands in a FIFO and replays them one at a time
// as single-cycle strobes. The optional write filter is enabled by SHAPE_CMD_SEQ_SHAPE_FILTER_EN.
module shape_cmd_sequencer #(
    parameter int DEPTH        = 4,
    parameter int READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_error,
    output logic        sfr_write,
    output logic [31:0] sfr_write_data,
    output logic        sfr_read,
    input  logic [31:0] sfr_read_data,
    input  logic        sfr_error,
    output logic [7:0]  reject_cnt,
    output logic [1:0]  dbg_state
);
    // Both channels transfer on a rising edge where valid && ready; once raised, rsp_valid and
    // rsp_data/rsp_error hold until that edge, and req_ready never depends on req_valid.
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t state, state_next;

    logic [31:0]   fifo_data  [DEPTH];
    logic          fifo_write [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          push;
    logic          pop;
    logic          empty;
    logic          head_write;
    logic [31:0]   head_data;
    logic          filter_hit;
    logic          issue;
    logic          reject;
    logic          capture;
    logic          cmd_write;
    logic [2:0]    wait_cnt;

    assign empty      = (count == '0);
    assign req_ready  = (count != CW'(DEPTH));
    assign push       = req_valid && req_ready;
    assign head_write = fifo_write[rd_ptr];
    assign head_data  = fifo_data[rd_ptr];
    assign dbg_state  = state;

`ifdef SHAPE_CMD_SEQ_SHAPE_FILTER_EN
    assign filter_hit = head_write && (head_data[17:16] == 2'b11);
`else
    assign filter_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr]  <= req_data;
            fifo_write[wr_ptr] <= req_write;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        issue      = 1'b0;
        reject     = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop = 1'b1;
                    if (filter_hit) begin
                        reject     = 1'b1;
                        state_next = RESP;
                    end else begin
                        issue      = 1'b1;
                        state_next = ISSUE;
                    end
                end
            end
            ISSUE: state_next = WAIT;
            WAIT: begin
                // The counter is loaded with READ_LATENCY, so reaching zero lands on the
                // edge where the SFR block presents its result.
                if (wait_cnt == 3'd1) begin
                    capture    = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sfr_write      <= 1'b0;
            sfr_read       <= 1'b0;
            sfr_write_data <= '0;
            cmd_write      <= 1'b0;
            wait_cnt       <= '0;
        end else begin
            sfr_write <= issue && head_write;
            sfr_read  <= issue && !head_write;
            if (issue) begin
                cmd_write <= head_write;
                if (head_write) begin
                    sfr_write_data <= head_data;
                end
            end
            if (state == ISSUE) begin
                wait_cnt <= 3'(READ_LATENCY);
            end else if (state == WAIT) begin
                wait_cnt <= wait_cnt - 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_error <= 1'b0;
        end else if (capture) begin
            rsp_valid <= 1'b1;
            rsp_data  <= cmd_write ? 32'h0 : sfr_read_data;
            rsp_error <= sfr_error;
        end else if (reject) begin
            rsp_valid <= 1'b1;
            rsp_data  <= '0;
            rsp_error <= 1'b1;
        end else if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

`ifdef SHAPE_CMD_SEQ_SHAPE_FILTER_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reject_cnt <= '0;
        end else if (reject && (reject_cnt != 8'hff)) begin
            reject_cnt <= reject_cnt + 8'd1;
        end
    end
`else
    assign reject_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_shape_cmd_sequencer.sv
// Bench for shape_cmd_sequencer: directed vector table, FIFO-full and mid-operation reset
// sequences, and randomized traffic checked against an in-order command/response model.
module tb_shape_cmd_sequencer;
    localparam int DEPTH = 4;
    localparam int RL    = 3;
    localparam int NRM   = 2 + RL;
`ifdef SHAPE_CMD_SEQ_SHAPE_FILTER_EN
    localparam bit FILT_EN = 1'b1;
`else
    localparam bit FILT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [31:0] req_data = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic        rsp_error;
    logic        sfr_write;
    logic [31:0] sfr_write_data;
    logic        sfr_read;
    logic [31:0] sfr_read_data = '1;
    logic        sfr_error = 1'b1;
    logic [7:0]  reject_cnt;
    logic [1:0]  dbg_state;

    always #5 clk = ~clk;

    shape_cmd_sequencer #(.DEPTH(DEPTH), .READ_LATENCY(RL)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_error(rsp_error),
        .sfr_write(sfr_write), .sfr_write_data(sfr_write_data), .sfr_read(sfr_read),
        .sfr_read_data(sfr_read_data), .sfr_error(sfr_error),
        .reject_cnt(reject_cnt), .dbg_state(dbg_state)
    );

    typedef struct {
        logic        w;
        logic [31:0] d;
        logic [31:0] rd;
        logic        err;
        logic [31:0] exp_data;
        logic        exp_err;
        logic        exp_w;
        logic        exp_r;
        int          exp_delay;
        logic [7:0]  exp_rej;
    } vec_t;

    typedef struct {
        logic        w;
        logic [31:0] d;
    } cmd_t;

    int          tests = 0;
    int          fails = 0;
    vec_t        vecs[7];
    cmd_t        cmd_q[$];
    logic [32:0] exp_q[$];
    int          rsp_count = 0;
    int          rej_model = 0;
    bit          hold = 1'b0;

    // SFR responder state: result is valid only on the edge RL edges after the strobe edge.
    int          cd = 0;
    bit          armed = 1'b0;
    bit          auto_sfr = 1'b0;
    logic [31:0] sfr_rd_val = '0;
    logic        sfr_err_val = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic bit is_filt(input logic w, input logic [31:0] d);
        return FILT_EN && w && (d[17:16] == 2'b11);
    endfunction

    task automatic cycle();
        @(negedge clk);
        if (sfr_write || sfr_read) begin
            cd    = RL;
            armed = 1'b1;
            if (auto_sfr) begin
                sfr_rd_val  = $urandom;
                sfr_err_val = 1'($urandom_range(0, 1));
            end
        end else if (armed) begin
            cd--;
        end
        if (armed && cd == 0) begin
            sfr_read_data = sfr_rd_val;
            sfr_error     = sfr_err_val;
            armed         = 1'b0;
        end else begin
            sfr_read_data = ~sfr_rd_val;
            sfr_error     = ~sfr_err_val;
        end
    endtask

    task automatic mon_outputs();
        cmd_t        h;
        logic [32:0] e;
        bit          have;
        check("strobe_exclusive", 32'(sfr_write && sfr_read), 0);
        if (hold) begin
            check("hold_valid", rsp_valid, 1);
        end
        if (sfr_write || sfr_read) begin
            check("strobe_no_rsp", rsp_valid, 0);
            check("strobe_has_cmd", 32'(cmd_q.size() != 0 && exp_q.size() == 0), 1);
            if (cmd_q.size() != 0 && exp_q.size() == 0) begin
                h = cmd_q.pop_front();
                check("strobe_type", sfr_write, h.w);
                check("strobe_not_filtered", 32'(is_filt(h.w, h.d)), 0);
                if (h.w) begin
                    check("strobe_wdata", sfr_write_data, h.d);
                end
                exp_q.push_back({sfr_err_val, h.w ? 32'h0 : sfr_rd_val});
            end
        end
        if (rsp_valid) begin
            have = 1'b0;
            e    = '0;
            if (exp_q.size() != 0) begin
                have = 1'b1;
                e    = exp_q[0];
            end else if (cmd_q.size() != 0) begin
                have = is_filt(cmd_q[0].w, cmd_q[0].d);
                e    = {1'b1, 32'h0};
            end
            check("rsp_expected", 32'(have), 1);
            if (have) begin
                check("rsp_data", rsp_data, e[31:0]);
                check("rsp_error", rsp_error, e[32]);
            end
        end
    endtask

    task automatic mon_handshakes();
        hold = rsp_valid && !rsp_ready;
        if (rsp_valid && rsp_ready) begin
            rsp_count++;
            if (exp_q.size() != 0) begin
                exp_q.delete(0);
            end else if (cmd_q.size() != 0 && is_filt(cmd_q[0].w, cmd_q[0].d)) begin
                cmd_q.delete(0);
                rej_model = (rej_model == 255) ? 255 : rej_model + 1;
            end
        end
        if (req_valid && req_ready) begin
            cmd_q.push_back('{req_write, req_data});
            check("capacity", 32'(cmd_q.size() + exp_q.size() <= DEPTH + 1), 1);
        end
    endtask

    task automatic run_vec(input int i);
        vec_t v;
        v           = vecs[i];
        sfr_rd_val  = v.rd;
        sfr_err_val = v.err;
        check($sformatf("v%0d_req_ready", i), req_ready, 1);
        req_valid = 1'b1;
        req_write = v.w;
        req_data  = v.d;
        rsp_ready = 1'b1;
        cycle();
        req_valid = 1'b0;
        for (int k = 0; k <= v.exp_delay; k++) begin
            if (k > 0) begin
                cycle();
            end
            check($sformatf("v%0d_sfr_write_k%0d", i, k), sfr_write, 32'(k == 1 && v.exp_w));
            check($sformatf("v%0d_sfr_read_k%0d", i, k), sfr_read, 32'(k == 1 && v.exp_r));
            if (k == 1 && v.exp_w) begin
                check($sformatf("v%0d_wdata", i), sfr_write_data, v.d);
            end
            check($sformatf("v%0d_rsp_valid_k%0d", i, k), rsp_valid, 32'(k == v.exp_delay));
        end
        check($sformatf("v%0d_rsp_data", i), rsp_data, v.exp_data);
        check($sformatf("v%0d_rsp_error", i), rsp_error, v.exp_err);
        check($sformatf("v%0d_reject_cnt", i), reject_cnt, v.exp_rej);
        cycle();
        check($sformatf("v%0d_rsp_done", i), rsp_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] fill_w;
        int         base;

        vecs[0] = '{1'b0, 32'h0000_0000, 32'h0001_0000, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 1'b1, NRM, 8'd0};
        vecs[1] = '{1'b1, 32'h0002_0010, 32'h1111_1111, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, NRM, 8'd0};
        vecs[2] = '{1'b0, 32'h0000_0000, 32'hdead_beef, 1'b1, 32'hdead_beef, 1'b1, 1'b0, 1'b1, NRM, 8'd0};
        vecs[3] = '{1'b1, 32'h1234_5678, 32'h2222_2222, 1'b1, 32'h0, 1'b1, 1'b1, 1'b0, NRM, 8'd0};
`ifdef SHAPE_CMD_SEQ_SHAPE_FILTER_EN
        vecs[4] = '{1'b1, 32'h0003_0000, 32'h3333_3333, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1, 8'd1};
        vecs[6] = '{1'b1, 32'hffff_ffff, 32'h4444_4444, 1'b1, 32'h0, 1'b1, 1'b0, 1'b0, 1, 8'd2};
`else
        vecs[4] = '{1'b1, 32'h0003_0000, 32'h3333_3333, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, NRM, 8'd0};
        vecs[6] = '{1'b1, 32'hffff_ffff, 32'h4444_4444, 1'b1, 32'h0, 1'b1, 1'b1, 1'b0, NRM, 8'd0};
`endif
        vecs[5] = '{1'b0, 32'h0003_0000, 32'h0000_00ff, 1'b0, 32'h0000_00ff, 1'b0, 1'b0, 1'b1, NRM, 8'(FILT_EN)};

        // Reset state
        cycle();
        cycle();
        check("rst_req_ready", req_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_rsp_error", rsp_error, 0);
        check("rst_sfr_write", sfr_write, 0);
        check("rst_sfr_read", sfr_read, 0);
        check("rst_sfr_write_data", sfr_write_data, 0);
        check("rst_reject_cnt", reject_cnt, 0);
        rst_n = 1'b1;
        cycle();

        // Single-command vectors with exact strobe and response timing
        auto_sfr = 1'b0;
        for (int i = 0; i < 7; i++) begin
            run_vec(i);
        end
        rej_model = 2 * int'(FILT_EN);

        // Fill the FIFO while the response is stalled, then drain in order
        auto_sfr  = 1'b1;
        hold      = 1'b0;
        rsp_ready = 1'b0;
        base      = rsp_count;
        fill_w    = 5'b10010;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin
                cycle();
                mon_outputs();
            end
            check($sformatf("fill_ready_%0d", i), req_ready, 1);
            req_valid = 1'b1;
            req_write = fill_w[i];
            req_data  = 32'h1000_0000 + 32'(i);
            mon_handshakes();
        end
        cycle();
        mon_outputs();
        check("fill_full", req_ready, 0);
        req_write = 1'b0;
        req_data  = 32'h1000_0005;
        mon_handshakes();
        for (int c = 0; c < 12; c++) begin
            cycle();
            mon_outputs();
            check("full_hold_ready", req_ready, 0);
            mon_handshakes();
        end
        cycle();
        mon_outputs();
        check("rsp_waiting", rsp_valid, 1);
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        mon_handshakes();
        for (int c = 0; c < 200 && (cmd_q.size() != 0 || exp_q.size() != 0); c++) begin
            cycle();
            mon_outputs();
            mon_handshakes();
        end
        check("fill_drained", 32'(cmd_q.size() + exp_q.size()), 0);
        check("fill_rsp_count", 32'(rsp_count - base), 5);

        // Randomized traffic against the in-order model
        for (int c = 0; c < 600; c++) begin
            cycle();
            mon_outputs();
            req_valid = ($urandom_range(0, 99) < 50);
            req_write = 1'($urandom_range(0, 1));
            req_data  = $urandom;
            if ($urandom_range(0, 3) == 0) begin
                req_data[17:16] = 2'b11;
            end
            rsp_ready = ($urandom_range(0, 99) < 60);
            mon_handshakes();
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        mon_handshakes();
        for (int c = 0; c < 200 && (cmd_q.size() != 0 || exp_q.size() != 0); c++) begin
            cycle();
            mon_outputs();
            mon_handshakes();
        end
        check("rand_drained", 32'(cmd_q.size() + exp_q.size()), 0);
        check("rand_reject_cnt", reject_cnt, 32'(rej_model));

        // Reset asserted while a read waits on the SFR latency with the FIFO full
        cycle();
        req_valid = 1'b1;
        req_write = 1'b0;
        req_data  = 32'h0;
        cycle();
        for (int k = 0; k < 4; k++) begin
            req_write = 1'b1;
            req_data  = 32'h0000_1000 + 32'(k);
            cycle();
        end
        req_valid = 1'b0;
        check("mid_full", req_ready, 0);
        check("mid_no_rsp_yet", rsp_valid, 0);
        rst_n = 1'b0;
        #1;
        armed = 1'b0;
        check("mid_rst_sfr_write", sfr_write, 0);
        check("mid_rst_sfr_read", sfr_read, 0);
        check("mid_rst_rsp_valid", rsp_valid, 0);
        check("mid_rst_req_ready", req_ready, 1);
        check("mid_rst_reject_cnt", reject_cnt, 0);
        cycle();
        rst_n = 1'b1;
        for (int c = 0; c < RL + 6; c++) begin
            cycle();
            check("post_rst_rsp_valid", rsp_valid, 0);
            check("post_rst_strobe", 32'(sfr_write || sfr_read), 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
